rr_mux4_arbiter: RTL and testbench

- Round-robin arbiter that shares a single 4:1 mux datapath between four requesters.
- Registers a one-hot grant and drives the 2-bit mux select from it.
- Forwards the winning requester's data word to `data_out`.
- Enforces a maximum hold time so that no requester can monopolise the shared path.

---
 rtl/rr_mux4_arbiter.sv | 129 ++++++++++++
 tb/tb_rr_mux4_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux datapath between four requesters.
// Registered one-hot grant and select; hold counter force-releases long grants.

module rr_mux4_lane #(
  parameter int W = 1
) (
  input  logic [W-1:0] data_i,
  input  logic         en_i,
  output logic [W-1:0] data_o
);
  assign data_o = en_i ? data_i : '0;
endmodule

module rr_mux4_arbiter #(
  parameter int W        = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic           done,
  input  logic [4*W-1:0] data_in,
  output logic [3:0]     grant,
  output logic [1:0]     sel,
  output logic           busy,
  output logic [W-1:0]   data_out,
  output logic           timeout
);
  localparam int         NUM_LANES = 4;
  localparam logic       HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LIM  = 8'(MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  logic [1:0] win;
  logic       hit_lim;
  logic       rel;

  // Lowest rotated offset from ptr wins, so scan offsets high-to-low.
  always_comb begin
    win = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (req[ptr_q + 2'(i)]) win = ptr_q + 2'(i);
    end
  end

  assign hit_lim = HOLD_EN && (cnt_q == HOLD_LIM);
  assign rel     = done || !req[sel_q] || hit_lim;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          grant_d = 4'b0001 << win;
          sel_d   = win;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (rel) begin
          state_d   = IDLE;
          grant_d   = '0;
          ptr_d     = sel_q + 2'd1;
          // Timeout flags only a release the owner did not ask for.
          timeout_d = hit_lim && !done && req[sel_q];
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign busy    = (state_q == BUSY);
  assign timeout = timeout_q;

  logic [NUM_LANES-1:0][W-1:0] lane_data;

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      rr_mux4_lane #(.W(W)) u_lane (
        .data_i (data_in[W*k +: W]),
        .en_i   (busy && (sel_q == 2'(k))),
        .data_o (lane_data[k])
      );
    end
  endgenerate

  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_LANES; i++) data_out = data_out | lane_data[i];
  end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter: stimulus queues expected outputs,
// a monitor pops one entry per clock and compares.

module tb_rr_mux4_arbiter;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req;
  logic           done;
  logic [4*W-1:0] data_in;
  logic [3:0]     grant;
  logic [1:0]     sel;
  logic           busy;
  logic [W-1:0]   data_out;
  logic           timeout;

  rr_mux4_arbiter #(.W(W), .MAX_HOLD(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .data_in  (data_in),
    .grant    (grant),
    .sel      (sel),
    .busy     (busy),
    .data_out (data_out),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   g;
    logic [1:0]   s;
    logic         b;
    logic         t;
    logic [W-1:0] d;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [15:0] DAT  = 16'hDCBA;
  localparam logic [15:0] DAT2 = 16'h0100;

  // One clock of stimulus; expectation is the output state after that edge.
  task automatic cyc(input logic r, input logic [3:0] rq, input logic dn,
                     input logic [15:0] dat, input logic [3:0] eg,
                     input logic [1:0] es, input logic eb, input logic et,
                     input logic [3:0] ed);
    exp_t e;
    @(negedge clk);
    rst = r; req = rq; done = dn; data_in = dat;
    e.g = eg; e.s = es; e.b = eb; e.t = et; e.d = ed;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (grant !== e.g) begin bad++; $display("FAIL grant got=%b want=%b t=%0t", grant, e.g, $time); end
      total++;
      if (sel !== e.s) begin bad++; $display("FAIL sel got=%0d want=%0d t=%0t", sel, e.s, $time); end
      total++;
      if (busy !== e.b) begin bad++; $display("FAIL busy got=%b want=%b t=%0t", busy, e.b, $time); end
      total++;
      if (timeout !== e.t) begin bad++; $display("FAIL timeout got=%b want=%b t=%0t", timeout, e.t, $time); end
      total++;
      if (data_out !== e.d) begin bad++; $display("FAIL data_out got=%h want=%h t=%0t", data_out, e.d, $time); end
    end
  end

  initial begin
    rst = 1'b1; req = '0; done = 1'b0; data_in = '0;
    // reset with all requesting, then first grant goes to 0
    cyc(1, 4'hF, 0, DAT, 4'h0, 0, 0, 0, 4'h0);
    cyc(1, 4'hF, 0, DAT, 4'h0, 0, 0, 0, 4'h0);
    cyc(0, 4'hF, 0, DAT, 4'h1, 0, 1, 0, 4'hA);
    cyc(0, 4'hF, 1, DAT, 4'h0, 0, 0, 0, 4'h0);
    // fairness rotation with done every busy cycle (done also held in one idle cycle)
    cyc(0, 4'hF, 0, DAT, 4'h2, 1, 1, 0, 4'hB);
    cyc(0, 4'hF, 1, DAT, 4'h0, 1, 0, 0, 4'h0);
    cyc(0, 4'hF, 1, DAT, 4'h4, 2, 1, 0, 4'hC);
    cyc(0, 4'hF, 1, DAT, 4'h0, 2, 0, 0, 4'h0);
    cyc(0, 4'hF, 0, DAT, 4'h8, 3, 1, 0, 4'hD);
    cyc(0, 4'hF, 1, DAT, 4'h0, 3, 0, 0, 4'h0);
    cyc(0, 4'hF, 0, DAT, 4'h1, 0, 1, 0, 4'hA);
    cyc(0, 4'hF, 1, DAT, 4'h0, 0, 0, 0, 4'h0);
    // idle with no requests: sel holds
    cyc(0, 4'h0, 0, DAT, 4'h0, 0, 0, 0, 4'h0);
    // single request on channel 2, then ptr=3 gives channel 3 priority
    cyc(0, 4'h4, 0, DAT2, 4'h4, 2, 1, 0, 4'h1);
    cyc(0, 4'h4, 0, DAT2, 4'h4, 2, 1, 0, 4'h1);
    cyc(0, 4'h4, 1, DAT2, 4'h0, 2, 0, 0, 4'h0);
    cyc(0, 4'hF, 0, DAT, 4'h8, 3, 1, 0, 4'hD);
    cyc(0, 4'hF, 1, DAT, 4'h0, 3, 0, 0, 4'h0);
    // timeout: 8 busy cycles, pulse on release, regrant after dead cycle
    for (int i = 0; i < 8; i++) cyc(0, 4'h2, 0, DAT, 4'h2, 1, 1, 0, 4'hB);
    cyc(0, 4'h2, 0, DAT, 4'h0, 1, 0, 1, 4'h0);
    for (int i = 0; i < 8; i++) cyc(0, 4'h2, 0, DAT, 4'h2, 1, 1, 0, 4'hB);
    // done coinciding with the limit is a normal release
    cyc(0, 4'h2, 1, DAT, 4'h0, 1, 0, 0, 4'h0);
    // owner drop: ptr=2 so 0001 wins, then drop to 1000
    cyc(0, 4'h1, 0, DAT, 4'h1, 0, 1, 0, 4'hA);
    cyc(0, 4'h8, 0, DAT, 4'h0, 0, 0, 0, 4'h0);
    cyc(0, 4'h8, 0, DAT, 4'h8, 3, 1, 0, 4'hD);
    cyc(0, 4'h8, 1, DAT, 4'h0, 3, 0, 0, 4'h0);
    // reset mid-grant with ptr=1 beforehand: next grant must be 0001
    cyc(0, 4'hF, 0, DAT, 4'h1, 0, 1, 0, 4'hA);
    cyc(0, 4'hF, 1, DAT, 4'h0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 6; i++) cyc(0, 4'h4, 0, DAT, 4'h4, 2, 1, 0, 4'hC);
    cyc(1, 4'h4, 0, DAT, 4'h0, 0, 0, 0, 4'h0);
    cyc(0, 4'hF, 0, DAT, 4'h1, 0, 1, 0, 4'hA);
    cyc(0, 4'hF, 1, DAT, 4'h0, 0, 0, 0, 4'h0);
    cyc(0, 4'h0, 0, DAT, 4'h0, 0, 0, 0, 4'h0);

    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
